// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock controller: state encoding, detector
// reset pulse length and error accumulator sizing.
package pll_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PD_RST  = 3'd1;
    localparam logic [2:0] ST_ACQUIRE = 3'd2;
    localparam logic [2:0] ST_TRACK   = 3'd3;
    localparam logic [2:0] ST_LOCKED  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_PD_RST  = ST_PD_RST,
        S_ACQUIRE = ST_ACQUIRE,
        S_TRACK   = ST_TRACK,
        S_LOCKED  = ST_LOCKED
    } state_t;

    localparam int PD_RST_LEN = 4;

    // Window total spans [-WIN, +WIN]; one extra bit for sign, one for +WIN itself.
    function automatic int err_w(input int win);
        return $clog2(win) + 2;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for the asynchronous phase detector pulses.
module sync2 (
    input  logic clk,
    input  logic ff_rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge ff_rst) begin
        if (ff_rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL digital loop controller: integrates PFD up/dn error over fixed windows,
// steers a saturating DCO control word and sequences acquire/track/lock.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int CW         = 10,
    parameter int WIN        = 64,
    parameter int INIT       = 512,
    parameter int KA         = 2,
    parameter int KT         = 4,
    parameter int ACQ_TOL    = 16,
    parameter int LOCK_TOL   = 2,
    parameter int UNLOCK_TOL = 6,
    parameter int LOCK_CNT   = 8
) (
    input  logic          clk,
    input  logic          ff_rst,
    input  logic          en,
    input  logic          up,
    input  logic          dn,
    output logic          pd_rst,
    output logic [CW-1:0] ctrl_word,
    output logic          locked,
    output logic [2:0]    state
);

    localparam int EW = err_w(WIN);
    localparam int WW = $clog2(WIN);
    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam int PW = $clog2(PD_RST_LEN);

    localparam logic [WW-1:0] WIN_LAST  = WW'(WIN - 1);
    localparam logic [PW-1:0] PD_LAST   = PW'(PD_RST_LEN - 1);
    localparam logic [LW-1:0] LOCK_N    = LW'(LOCK_CNT);
    localparam logic [EW-1:0] ACQ_T     = EW'(ACQ_TOL);
    localparam logic [EW-1:0] LOCK_T    = EW'(LOCK_TOL);
    localparam logic [EW-1:0] UNLOCK_T  = EW'(UNLOCK_TOL);
    localparam logic [CW-1:0] INIT_W    = CW'(INIT);

    function automatic logic [CW-1:0] sat_cw(input logic signed [CW+1:0] v);
        if (v[CW+1])
            return '0;
        else if (v[CW])
            return '1;
        else
            return v[CW-1:0];
    endfunction

    function automatic logic [EW-1:0] abs_e(input logic signed [EW-1:0] v);
        return v[EW-1] ? -v : v;
    endfunction

    logic up_s, dn_s;

    sync2 u_sync_up (.clk(clk), .ff_rst(ff_rst), .d(up), .q(up_s));
    sync2 u_sync_dn (.clk(clk), .ff_rst(ff_rst), .d(dn), .q(dn_s));

    // ---- stage p0: per-cycle signed error from synchronised pulses
    logic signed [EW-1:0] err_p0;

    always_comb begin
        err_p0 = '0;
        case ({up_s, dn_s})
            2'b10:   err_p0 = {{(EW-1){1'b0}}, 1'b1};
            2'b01:   err_p0 = '1;
            default: err_p0 = '0;
        endcase
    end

    // ---- stage p1: window integration, total latched with win_done
    state_t               state_q, state_d;
    logic [WW-1:0]        win_cnt;
    logic signed [EW-1:0] err_acc;
    logic signed [EW-1:0] err_win_p1;
    logic                 win_done;
    logic                 active;

    assign active = en && (state_q == S_ACQUIRE || state_q == S_TRACK || state_q == S_LOCKED);

    always_ff @(posedge clk or posedge ff_rst) begin
        if (ff_rst) begin
            win_cnt    <= '0;
            err_acc    <= '0;
            err_win_p1 <= '0;
            win_done   <= 1'b0;
        end else if (!active) begin
            win_cnt  <= '0;
            err_acc  <= '0;
            win_done <= 1'b0;
        end else if (win_cnt == WIN_LAST) begin
            err_win_p1 <= err_acc + err_p0;
            win_done   <= 1'b1;
            err_acc    <= '0;
            win_cnt    <= '0;
        end else begin
            err_acc  <= err_acc + err_p0;
            win_cnt  <= win_cnt + 1'b1;
            win_done <= 1'b0;
        end
    end

    // ---- stage p2: gain, saturating update and state machine
    logic [CW-1:0]          ctrl_q, ctrl_d;
    logic [LW-1:0]          lock_cnt_q, lock_cnt_d, lock_inc;
    logic [PW-1:0]          pd_cnt_q, pd_cnt_d;
    logic                   pd_rst_q, locked_q;
    logic signed [CW+1:0]   err_x, step_p2, sum_p2;
    logic [EW-1:0]          mag_p2;

    assign err_x    = {{(CW+2-EW){err_win_p1[EW-1]}}, err_win_p1};
    assign step_p2  = (state_q == S_ACQUIRE) ? (err_x >>> KA) : (err_x >>> KT);
    assign sum_p2   = $signed({2'b00, ctrl_q}) + step_p2;
    assign mag_p2   = abs_e(err_win_p1);
    assign lock_inc = lock_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        lock_cnt_d = lock_cnt_q;
        pd_cnt_d   = pd_cnt_q;
        if (!en) begin
            state_d    = S_IDLE;
            ctrl_d     = INIT_W;
            lock_cnt_d = '0;
            pd_cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ctrl_d     = INIT_W;
                    lock_cnt_d = '0;
                    pd_cnt_d   = '0;
                    state_d    = S_PD_RST;
                end
                S_PD_RST: begin
                    if (pd_cnt_q == PD_LAST) begin
                        pd_cnt_d = '0;
                        state_d  = S_ACQUIRE;
                    end else begin
                        pd_cnt_d = pd_cnt_q + 1'b1;
                    end
                end
                S_ACQUIRE, S_TRACK, S_LOCKED: begin
                    if (win_done) begin
                        ctrl_d = sat_cw(sum_p2);
                        if (state_q == S_ACQUIRE) begin
                            if (mag_p2 <= ACQ_T) begin
                                state_d    = S_TRACK;
                                lock_cnt_d = '0;
                            end
                        end else if (state_q == S_TRACK) begin
                            if (mag_p2 > ACQ_T) begin
                                state_d = S_ACQUIRE;
                            end else if (mag_p2 <= LOCK_T) begin
                                lock_cnt_d = lock_inc;
                                if (lock_inc == LOCK_N)
                                    state_d = S_LOCKED;
                            end else begin
                                lock_cnt_d = '0;
                            end
                        end else if (mag_p2 > UNLOCK_T) begin
                            state_d    = S_TRACK;
                            lock_cnt_d = '0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // pd_rst and locked are decoded from the next state so they move with it.
    always_ff @(posedge clk or posedge ff_rst) begin
        if (ff_rst) begin
            state_q    <= S_IDLE;
            ctrl_q     <= INIT_W;
            lock_cnt_q <= '0;
            pd_cnt_q   <= '0;
            pd_rst_q   <= 1'b1;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            lock_cnt_q <= lock_cnt_d;
            pd_cnt_q   <= pd_cnt_d;
            pd_rst_q   <= (state_d == S_IDLE) || (state_d == S_PD_RST);
            locked_q   <= (state_d == S_LOCKED);
        end
    end

    assign state     = state_q;
    assign ctrl_word = ctrl_q;
    assign locked    = locked_q;
    assign pd_rst    = pd_rst_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboard bench for pll_lock_ctrl: window-level reference model drives
// expected outputs into a queue that is drained as the DUT reaches each point.
module tb_pll_lock_ctrl;

    logic       clk = 1'b0;
    logic       ff_rst, en, up, dn;
    logic       pd_rst, locked;
    logic [9:0] ctrl_word;
    logic [2:0] state;

    pll_lock_ctrl dut (
        .clk(clk), .ff_rst(ff_rst), .en(en), .up(up), .dn(dn),
        .pd_rst(pd_rst), .ctrl_word(ctrl_word), .locked(locked), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        string      tag;
        logic [2:0] st;
        logic       pr;
        logic [9:0] cw;
        logic       lk;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   stepn  = 0;
    int   m_state, m_cw, m_lc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int due, input string tag);
        exp_t e;
        e.due = due;
        e.tag = tag;
        e.st  = 3'(m_state);
        e.pr  = (m_state <= 1);
        e.cw  = 10'(m_cw);
        e.lk  = (m_state == 4);
        sb.push_back(e);
    endtask

    // One clock: observe outputs of the previous edge, then drive the next one.
    task automatic step(input logic e_v, input logic u_v, input logic d_v);
        exp_t x;
        @(negedge clk);
        stepn++;
        while (sb.size() > 0 && sb[0].due <= stepn) begin
            x = sb.pop_front();
            check_val({x.tag, ".state"},  32'(state),     32'(x.st));
            check_val({x.tag, ".pd_rst"}, 32'(pd_rst),    32'(x.pr));
            check_val({x.tag, ".ctrl"},   32'(ctrl_word), 32'(x.cw));
            check_val({x.tag, ".locked"}, 32'(locked),    32'(x.lk));
        end
        en = e_v;
        up = u_v;
        dn = d_v;
    endtask

    task automatic model_window(input int e);
        int k, st, a;
        k  = (m_state == 2) ? 2 : 4;
        st = e >>> k;
        m_cw = m_cw + st;
        if (m_cw < 0)    m_cw = 0;
        if (m_cw > 1023) m_cw = 1023;
        a = (e < 0) ? -e : e;
        case (m_state)
            2: if (a <= 16) begin m_state = 3; m_lc = 0; end
            3: begin
                if (a > 16) m_state = 2;
                else if (a <= 2) begin
                    m_lc++;
                    if (m_lc == 8) m_state = 4;
                end else m_lc = 0;
            end
            4: if (a > 6) begin m_state = 3; m_lc = 0; end
            default: ;
        endcase
    endtask

    // Net error e, mixed with cancelling up/dn/both/none groups of four.
    task automatic pattern(input int e, input int j, output logic u, output logic d);
        int a, r;
        a = (e < 0) ? -e : e;
        u = 1'b0;
        d = 1'b0;
        if (j < a) begin
            u = (e > 0);
            d = (e < 0);
        end else begin
            r = j - a;
            if (r < ((64 - a) / 4) * 4) begin
                case (r % 4)
                    0: u = 1'b1;
                    1: d = 1'b1;
                    2: begin u = 1'b1; d = 1'b1; end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic run_window(input int e, input string tag);
        logic u, d;
        int last;
        for (int j = 0; j < 64; j++) begin
            pattern(e, j, u, d);
            step(1'b1, u, d);
        end
        last = stepn;
        push_exp(last + 3, {tag, "/hold"});
        model_window(e);
        push_exp(last + 4, tag);
    endtask

    task automatic startup();
        int s;
        s = stepn + 1;
        m_state = 1;
        m_cw    = 512;
        m_lc    = 0;
        for (int k = 1; k <= 4; k++) push_exp(s + k, "pd_rst_pulse");
        m_state = 2;
        push_exp(s + 5, "acq_entry");
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic partial_window(input int n);
        logic u, d;
        for (int j = 0; j < n; j++) begin
            pattern(0, j, u, d);
            step(1'b1, u, d);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ff_rst = 1'b1;
        en     = 1'b0;
        up     = 1'b0;
        dn     = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst.pd_rst", 32'(pd_rst),    32'd1);
        check_val("rst.ctrl",   32'(ctrl_word), 32'd512);
        check_val("rst.locked", 32'(locked),    32'd0);
        check_val("rst.state",  32'(state),     32'd0);
        ff_rst  = 1'b0;
        m_state = 0;
        m_cw    = 512;
        m_lc    = 0;
        push_exp(stepn + 2, "idle");
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        startup();
        run_window(64, "acq_up");
        partial_window(20);
        m_state = 0;
        m_cw    = 512;
        m_lc    = 0;
        push_exp(stepn + 2, "en_abort");
        repeat (3) step(1'b0, 1'b0, 1'b0);

        startup();
        run_window(-64, "acq_dn");
        repeat (30) run_window(-64, "ramp_dn");
        run_window(-44, "to_5");
        run_window(-64, "sat_lo");
        repeat (63) run_window(64, "ramp_up");
        run_window(48, "to_1020");
        run_window(64, "sat_hi");

        run_window(0, "to_track");
        repeat (8) run_window(0, "lock_run");
        run_window(10, "unlock");
        run_window(-20, "reacq");

        run_window(0, "track2");
        repeat (5) run_window(0, "good5");
        run_window(3, "spoil");
        repeat (7) run_window(0, "good7");
        run_window(0, "relock");

        partial_window(20);
        #2;
        check_val("pre_rst.locked", 32'(locked), 32'(m_state == 4));
        ff_rst = 1'b1;
        #1;
        check_val("async_rst.state",  32'(state),     32'd0);
        check_val("async_rst.pd_rst", 32'(pd_rst),    32'd1);
        check_val("async_rst.ctrl",   32'(ctrl_word), 32'd512);
        check_val("async_rst.locked", 32'(locked),    32'd0);
        ff_rst = 1'b0;
        en     = 1'b0;
        check_val("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pll_lock_ctrl.md
# pll_lock_ctrl

Digital loop controller that sequences the PLL's phase-frequency detector. It samples the detector's asynchronous `up`/`dn` pulses on a fast system clock and integrates the signed phase error over fixed windows. It updates a saturating DCO control word with a state-dependent gain, and reports lock. It also owns the detector's reset line, holding it in reset while disabled and pulsing it on start-up.

## Interface
- `CW`, 10, DCO control word width
- `WIN`, 64, window length in `clk` cycles (power of two)
- `INIT`, 512, control word value after reset / while idle
- `KA`, 2, right-shift gain in ACQUIRE
- `KT`, 4, right-shift gain in TRACK and LOCKED
- `ACQ_TOL`, 16, \|err\| threshold ACQUIRE↔TRACK
- `LOCK_TOL`, 2, \|err\| threshold counted towards lock
- `UNLOCK_TOL`, 6, \|err\| above which LOCKED is lost
- `LOCK_CNT`, 8, consecutive in-tolerance windows required for lock

Ports:
- `clk`  in  1  sampling clock, ≥8× reference frequency
- `ff_rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  loop enable, synchronous level
- `up`  in  1  detector UP pulse, asynchronous
- `dn`  in  1  detector DN pulse, asynchronous
- `pd_rst`  out  1  reset to the phase detector, active-high
- `ctrl_word`  out  CW  DCO control code, unsigned
- `locked`  out  1  lock indication
- `state`  out  3  current state: IDLE=0, PD_RST=1, ACQUIRE=2, TRACK=3, LOCKED=4

## Operation
- `up` and `dn` each pass through a 2-flop synchroniser, producing `up_s` and `dn_s`.
- Per-cycle error: +1 if `up_s & !dn_s`, −1 if `dn_s & !up_s`, otherwise 0. Both high counts as 0.
- `err_acc` is a signed accumulator of width clog2(WIN)+2. `win_cnt` counts 0..WIN-1.
  - On the cycle where `win_cnt==WIN-1`, that cycle's error is included, `win_done` is registered, and the accumulator and counter restart.
- Window-end update uses the latched window total E:
  - step = E >>> K, an arithmetic shift that rounds toward −inf. K=KA in ACQUIRE, KT otherwise.
  - new = ctrl_word + step, computed at CW+2 bits signed and saturated to [0, 2^CW−1].
- State machine (transitions evaluated at window end unless noted):
  - IDLE: `pd_rst`=1, `ctrl_word`=INIT, counters cleared. When `en`=1, go to PD_RST.
  - PD_RST: `pd_rst`=1 for exactly 4 cycles, then go to ACQUIRE. `win_cnt`/`err_acc` are held at 0.
  - ACQUIRE: if \|E\|≤ACQ_TOL, go to TRACK and clear `lock_cnt`.
  - TRACK: if \|E\|>ACQ_TOL, go to ACQUIRE. Else if \|E\|≤LOCK_TOL, increment `lock_cnt`; on reaching LOCK_CNT, go to LOCKED. Else clear `lock_cnt`.
  - LOCKED: if \|E\|>UNLOCK_TOL, go to TRACK and clear `lock_cnt`. Otherwise stay.
  - `en`=0 in any state forces IDLE on the next edge. Any partial window is discarded and `ctrl_word` returns to INIT.
- `locked` is 1 exactly when `state`==LOCKED. It is registered and takes no extra cycle.
- `pd_rst` is 1 in IDLE and PD_RST, and 0 otherwise.

## Timing
- Reset values: `pd_rst`=1, `ctrl_word`=INIT, `locked`=0, `state`=IDLE, `win_cnt`=0, `err_acc`=0, `lock_cnt`=0.
- Input to accumulator latency is 3 cycles: 2 synchroniser cycles plus 1 accumulate cycle.
- The first window starts on the first cycle in ACQUIRE and spans exactly WIN cycles.
- `ctrl_word`, `state`, and `locked` update together, one cycle after the last sample of a window.
- `ff_rst` asserted mid-window clears everything immediately (asynchronous). Outputs return to reset values without waiting for a clock edge.
- The maximum \|E\| is WIN, which fits in the accumulator without overflow.

## Structure
- Package `pll_ctrl_pkg` holds the state encoding localparams (IDLE..LOCKED), the PD_RST pulse length (4), and the error-width function clog2(WIN)+2.
- Sub-module `sync2`: a 2-flop synchroniser, reset by `ff_rst` to 0, instantiated for `up` and `dn`.
- Everything else (accumulator, saturating adder, FSM) is in the top module.

## Test plan
- Reset and start-up:
  - With `ff_rst`=1: `pd_rst`=1, `ctrl_word`=512, `locked`=0, `state`=0.
  - Release `ff_rst`, then `en`=1: `state` goes to 1, `pd_rst` is high for 4 cycles, then `state`=2 and `pd_rst`=0.
- Acquire step:
  - `up` held high and `dn` low for one full window gives E=+64, and `ctrl_word` goes 512→528.
  - `dn` held high gives 512→496.
- Saturation:
  - `ctrl_word`=1020 with E=+64 clamps to 1023.
  - `ctrl_word`=5 with E=−64 clamps to 0.
- Lock sequence: with zero-error windows, window 1 moves to TRACK.
  - `locked` rises one cycle after window 9 ends.
  - A window with E=3 inserted after 5 good windows resets the count, so 8 further good windows are needed.
- Unlock:
  - In LOCKED, a window with E=+10 drops `locked`, sets `state`=3, and leaves `ctrl_word` unchanged (10>>>4=0).
  - A next window with E=−20 gives `state`=2 and `ctrl_word` −2.
- Abort:
  - `en`=0 mid-window: next edge `state`=0, `pd_rst`=1, `ctrl_word`=512.
  - `ff_rst` pulsed mid-window in LOCKED: outputs reset asynchronously, without waiting for a clock edge.
